// File: rtl/key_bounce_gen.sv
// Mechanical key emulator: drives an active-low key line through press bounce, hold,
// release bounce and idle gap, with bounce segment lengths taken from a 16-bit LFSR.
module key_bounce_gen #(
    parameter int unsigned HOLD_CYC     = 2_500_000,
    parameter int unsigned GAP_CYC      = 2_500_000,
    parameter int unsigned BOUNCE_PAIRS = 3,
    parameter int unsigned SEG_W        = 10,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       auto_repeat,
    output logic       key_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] press_cnt
);

    localparam int unsigned CNT_MAX   = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned TOG_N     = (BOUNCE_PAIRS == 0) ? 1 : 2 * BOUNCE_PAIRS;
    localparam int unsigned TOG_W     = (TOG_N > 2) ? $clog2(TOG_N) : 1;
    localparam int unsigned HOLD_LOAD = HOLD_CYC - 1;
    localparam int unsigned GAP_LOAD  = (GAP_CYC > 1) ? GAP_CYC - 2 : 0;
    localparam int unsigned TOG_LAST  = TOG_N - 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PB   = 3'd1,
        ST_HOLD = 3'd2,
        ST_RB   = 3'd3,
        ST_GAP  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             key_q, key_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       press_cnt_q, press_cnt_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [TOG_W-1:0] tog_q, tog_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic press_go;
    logic seg_go;
    logic gap_go;
    logic finish;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        done_d      = 1'b0;
        press_cnt_d = press_cnt_q;
        lfsr_d      = lfsr_q;
        seg_d       = seg_q;
        tog_d       = tog_q;
        cnt_d       = cnt_q;
        press_go    = 1'b0;
        seg_go      = 1'b0;
        gap_go      = 1'b0;
        finish      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    press_go = 1'b1;
                end
            end
            ST_PB: begin
                if (seg_q == '0) begin
                    key_d = ~key_q;
                    if (tog_q == TOG_W'(TOG_LAST)) begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_W'(HOLD_LOAD);
                    end else begin
                        tog_d  = tog_q + TOG_W'(1);
                        seg_go = 1'b1;
                    end
                end else begin
                    seg_d = seg_q - SEG_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    key_d = 1'b1;
                    if (BOUNCE_PAIRS == 0) begin
                        gap_go = 1'b1;
                    end else begin
                        state_d = ST_RB;
                        tog_d   = '0;
                        seg_go  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RB: begin
                if (seg_q == '0) begin
                    key_d = ~key_q;
                    if (tog_q == TOG_W'(TOG_LAST)) begin
                        gap_go = 1'b1;
                    end else begin
                        tog_d  = tog_q + TOG_W'(1);
                        seg_go = 1'b1;
                    end
                end else begin
                    seg_d = seg_q - SEG_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                key_d   = 1'b1;
            end
        endcase

        // The done edge is the first cycle of the last gap cycle, so a one-cycle gap
        // finishes straight out of the bounce/hold phase.
        if (gap_go) begin
            if (GAP_CYC <= 1) begin
                finish = 1'b1;
            end else begin
                state_d = ST_GAP;
                cnt_d   = CNT_W'(GAP_LOAD);
            end
        end

        if (finish) begin
            done_d      = 1'b1;
            press_cnt_d = press_cnt_q + 8'd1;
            key_d       = 1'b1;
            if (auto_repeat) begin
                press_go = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (press_go) begin
            key_d = 1'b0;
            if (BOUNCE_PAIRS == 0) begin
                state_d = ST_HOLD;
                cnt_d   = CNT_W'(HOLD_LOAD);
            end else begin
                state_d = ST_PB;
                tog_d   = '0;
                seg_go  = 1'b1;
            end
        end

        // A segment lasts 1 + lfsr[SEG_W-1:0] cycles using the pre-shift LFSR value.
        if (seg_go) begin
            seg_d  = lfsr_q[SEG_W-1:0];
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            key_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            press_cnt_q <= 8'd0;
            lfsr_q      <= LFSR_SEED;
            seg_q       <= '0;
            tog_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            press_cnt_q <= press_cnt_d;
            lfsr_q      <= lfsr_d;
            seg_q       <= seg_d;
            tog_q       <= tog_d;
            cnt_q       <= cnt_d;
        end
    end

    assign key_out   = key_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed bench for key_bounce_gen: three instances cover clean edges, LFSR bounce
// timing and auto-repeat wrap.
module tb_key_bounce_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic start0, ar0, key0, busy0, done0;
    logic start1, ar1, key1, busy1, done1;
    logic start2, ar2, key2, busy2, done2;
    logic [7:0] pc0, pc1, pc2;

    int checks   = 0;
    int failures = 0;

    key_bounce_gen #(.HOLD_CYC(10), .GAP_CYC(5), .BOUNCE_PAIRS(0), .SEG_W(3),
                     .LFSR_SEED(16'hACE1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .auto_repeat(ar0),
        .key_out(key0), .busy(busy0), .done(done0), .press_cnt(pc0));

    key_bounce_gen #(.HOLD_CYC(20), .GAP_CYC(10), .BOUNCE_PAIRS(2), .SEG_W(3),
                     .LFSR_SEED(16'hACE1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .auto_repeat(ar1),
        .key_out(key1), .busy(busy1), .done(done1), .press_cnt(pc1));

    key_bounce_gen #(.HOLD_CYC(3), .GAP_CYC(2), .BOUNCE_PAIRS(1), .SEG_W(2),
                     .LFSR_SEED(16'hACE1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .auto_repeat(ar2),
        .key_out(key2), .busy(busy2), .done(done2), .press_cnt(pc2));

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (key0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || pc0 !== 8'd0) begin
            failures++;
            $display("FAIL reset dut0: key=%b busy=%b done=%b cnt=%0d, want 1 0 0 0",
                     key0, busy0, done0, pc0);
        end
        checks++;
        if (key1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || pc1 !== 8'd0) begin
            failures++;
            $display("FAIL reset dut1: key=%b busy=%b done=%b cnt=%0d, want 1 0 0 0",
                     key1, busy1, done1, pc1);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_abort();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (5) step();
        checks++;
        if (key0 !== 1'b0 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre: key=%b busy=%b, want 0 1", key0, busy0);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (key0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || pc0 !== 8'd0) begin
            failures++;
            $display("FAIL abort_edge: key=%b busy=%b done=%b cnt=%0d, want 1 0 0 0",
                     key0, busy0, done0, pc0);
        end
        rst_n = 1'b1;
        repeat (20) step();
        checks++;
        if (key0 !== 1'b1 || busy0 !== 1'b0 || pc0 !== 8'd0) begin
            failures++;
            $display("FAIL abort_after: key=%b busy=%b cnt=%0d, want 1 0 0", key0, busy0, pc0);
        end
    endtask

    task automatic test_clean_edges();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            logic exp_key, exp_done, exp_busy;
            exp_key  = (i <= 10) ? 1'b0 : 1'b1;
            exp_done = (i == 15);
            exp_busy = (i < 15);
            checks++;
            if (key0 !== exp_key || done0 !== exp_done || busy0 !== exp_busy) begin
                failures++;
                $display("FAIL clean edge %0d: key=%b done=%b busy=%b, want %b %b %b",
                         i, key0, done0, busy0, exp_key, exp_done, exp_busy);
            end
            step();
        end
        checks++;
        if (pc0 !== 8'd1) begin
            failures++;
            $display("FAIL clean_cnt: cnt=%0d, want 1", pc0);
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int cyc   = 0;
        start0 = 1'b1;
        step();
        while (dones == 0 && cyc < 100) begin
            if (done0 === 1'b1) dones++;
            else step();
            cyc++;
        end
        start0 = 1'b0;
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL b2b_timeout: dones=%0d, want 1", dones);
        end
        repeat (30) begin
            step();
            if (done0 === 1'b1) dones++;
        end
        checks++;
        if (pc0 !== 8'd2 || busy0 !== 1'b0 || dones != 1) begin
            failures++;
            $display("FAIL b2b: cnt=%0d busy=%b dones=%0d, want 2 0 1", pc0, busy0, dones);
        end
    endtask

    task automatic run_bounce(input string name, input logic start_level,
                              inout logic [15:0] lfsr);
        logic level = start_level;
        for (int t = 0; t < 4; t++) begin
            int len = 1 + int'(lfsr[2:0]);
            int bad = 0;
            lfsr = lfsr_next(lfsr);
            for (int c = 0; c < len; c++) begin
                if (key1 !== level) bad++;
                step();
            end
            level = ~level;
            checks++;
            if (bad != 0 || key1 !== level) begin
                failures++;
                $display("FAIL %s seg%0d: len=%0d bad=%0d key_after=%b, want %b",
                         name, t, len, bad, key1, level);
            end
        end
    endtask

    task automatic test_bounce();
        logic [15:0] lfsr = 16'hACE1;
        int bad = 0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        run_bounce("pb", 1'b0, lfsr);
        for (int c = 0; c < 20; c++) begin
            if (key1 !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0 || key1 !== 1'b1) begin
            failures++;
            $display("FAIL hold: bad=%0d key_after=%b, want 0 1", bad, key1);
        end
        run_bounce("rb", 1'b1, lfsr);
        bad = 0;
        for (int c = 0; c < 9; c++) begin
            if (key1 !== 1'b1 || done1 !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0 || done1 !== 1'b1 || busy1 !== 1'b0 || pc1 !== 8'd1 || key1 !== 1'b1) begin
            failures++;
            $display("FAIL bounce_gap: bad=%0d done=%b busy=%b cnt=%0d key=%b, want 0 1 0 1 1",
                     bad, done1, busy1, pc1, key1);
        end
    endtask

    task automatic test_auto_repeat();
        int dones    = 0;
        int cyc      = 0;
        int busy_low = 0;
        int bad_done = 0;
        ar2    = 1'b1;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        while (dones < 257 && cyc < 20000) begin
            if (done2 === 1'b1) begin
                dones++;
                if (dones <= 256 && (key2 !== 1'b0 || pc2 !== 8'(dones))) bad_done++;
                if (dones == 256) begin
                    checks++;
                    if (pc2 !== 8'd0) begin
                        failures++;
                        $display("FAIL wrap: cnt=%0d, want 0", pc2);
                    end
                    ar2 = 1'b0;
                end
            end else if (busy2 !== 1'b1) begin
                busy_low++;
            end
            if (dones < 257) step();
            cyc++;
        end
        checks++;
        if (dones != 257) begin
            failures++;
            $display("FAIL repeat_timeout: dones=%0d, want 257", dones);
        end
        checks++;
        if (busy_low != 0 || bad_done != 0) begin
            failures++;
            $display("FAIL repeat: busy_drops=%0d bad_done_edges=%0d, want 0 0", busy_low, bad_done);
        end
        checks++;
        if (busy2 !== 1'b0 || key2 !== 1'b1 || pc2 !== 8'd1) begin
            failures++;
            $display("FAIL repeat_end: busy=%b key=%b cnt=%0d, want 0 1 1", busy2, key2, pc2);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0; ar0 = 1'b0;
        start1 = 1'b0; ar1 = 1'b0;
        start2 = 1'b0; ar2 = 1'b0;
        #1;
        test_reset();
        test_abort();
        test_clean_edges();
        test_back_to_back();
        test_bounce();
        test_auto_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
